// File: rtl/comparator_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
//   cmp_state_t  : FSM state encoding (IDLE, SCAN, DONE)
//   CMP_EQ/GT/LT : one-hot result encodings, bit order {eq, gt, lt}
//   digits_width : width of the digits-examined count for a given digit count
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  // Wide enough to hold the values 1..ndig.
  function automatic int unsigned digits_width(input int unsigned ndig);
    return $clog2(ndig) + 1;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit unsigned magnitude compare, gate-level style.
// Scans MSB to LSB: the first differing bit decides gt/lt. The result is always one-hot.
//   a, b : DIGIT-bit operands
//   eq   : a == b
//   gt   : a > b
//   lt   : a < b
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic eq_run;
  logic gt_acc;
  logic lt_acc;

  always_comb begin
    eq_run = 1'b1;
    gt_acc = 1'b0;
    lt_acc = 1'b0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      // A bit only decides the result while all higher bits are still equal.
      gt_acc = gt_acc | (eq_run & a[i] & ~b[i]);
      lt_acc = lt_acc | (eq_run & ~a[i] & b[i]);
      eq_run = eq_run & ~(a[i] ^ b[i]);
    end
  end

  assign eq = eq_run;
  assign gt = gt_acc;
  assign lt = lt_acc;

endmodule

// File: rtl/seq_mag_comparator.sv
// Digit-serial magnitude comparator. An operand pair is accepted over a valid/ready
// handshake, then scanned MSB-first DIGIT bits per cycle until the first unequal digit.
// The one-hot {eq, gt, lt} result and the number of digits examined are held until the
// consumer takes them.
// Optional feature macro: SEQ_MAG_COMPARATOR_SIGNED_EN (honours is_signed when defined).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid, in_ready   : operand handshake (in_ready only in IDLE)
//   a, b, is_signed      : operands, two's complement select sampled with them
//   out_valid, out_ready : result handshake (out_valid only in DONE)
//   eq, gt, lt           : registered one-hot result
//   digits               : digits examined for this result, 1..NDIG
module seq_mag_comparator
  import comparator_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DIGIT = 4,
  localparam int unsigned NDIG  = WIDTH / DIGIT,
  localparam int unsigned DW    = digits_width(NDIG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [DW-1:0]    digits
);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic             dig_eq, dig_gt, dig_lt;
  logic [WIDTH-1:0] cap_a, cap_b;

`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
  // Flipping both sign bits maps two's complement order onto unsigned order.
  always_comb begin
    cap_a = a;
    cap_b = b;
    cap_a[WIDTH-1] = a[WIDTH-1] ^ is_signed;
    cap_b[WIDTH-1] = b[WIDTH-1] ^ is_signed;
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign cap_a = a;
  assign cap_b = b;
`endif

  cmp_digit #(
    .DIGIT(DIGIT)
  ) u_cmp_digit (
    .a (sa_q[WIDTH-1 -: DIGIT]),
    .b (sb_q[WIDTH-1 -: DIGIT]),
    .eq(dig_eq),
    .gt(dig_gt),
    .lt(dig_lt)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) begin
          sa_d    = cap_a;
          sb_d    = cap_b;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + DW'(1);
        if (!dig_eq) begin
          eq_d     = 1'b0;
          gt_d     = dig_gt;
          lt_d     = dig_lt;
          digits_d = cnt_q + DW'(1);
          state_d  = DONE;
        end else if (cnt_q == DW'(NDIG - 1)) begin
          eq_d     = 1'b1;
          gt_d     = 1'b0;
          lt_d     = 1'b0;
          digits_d = cnt_q + DW'(1);
          state_d  = DONE;
        end else begin
          sa_d = sa_q << DIGIT;
          sb_d = sb_q << DIGIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign digits    = digits_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench for seq_mag_comparator (WIDTH=16, DIGIT=4).
// Expected results come from a full-width reference compare and are queued at accept time.
module tb_seq_mag_comparator;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned DW    = $clog2(NDIG) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             eq, gt, lt;
  logic [DW-1:0]    digits;

  typedef struct packed {
    logic          eq;
    logic          gt;
    logic          lt;
    logic [DW-1:0] digits;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  seq_mag_comparator #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .eq       (eq),
    .gt       (gt),
    .lt       (lt),
    .digits   (digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width compare; digits = position of first differing digit from MSB.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s);
    exp_t             r;
    logic             sgn;
    logic [WIDTH-1:0] d;
    bit               found;
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
    sgn = s;
`else
    sgn = 1'b0;
`endif
    r.eq = (x == y);
    r.gt = sgn ? ($signed(x) > $signed(y)) : (x > y);
    r.lt = sgn ? ($signed(x) < $signed(y)) : (x < y);
    d = x ^ y;
    found = 1'b0;
    r.digits = DW'(NDIG);
    for (int i = 0; i < NDIG; i++) begin
      if (!found && d[WIDTH-1-i*DIGIT -: DIGIT] != '0) begin
        r.digits = DW'(i + 1);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Drive a pair at a negedge, let the next posedge accept it, return at the following negedge.
  task automatic start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    is_signed = s;
    in_valid = 1'b1;
    sb.push_back(model(x, y, s));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the accept edge; checks latency and result.
  task automatic wait_result(input string tag, input bit release_out);
    int   lat = 0;
    exp_t e;
    while (!out_valid && lat < int'(NDIG) + 4) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(lat), 32'(e.digits));
      check({tag, "_eqgtlt"}, 32'({eq, gt, lt}), 32'({e.eq, e.gt, e.lt}));
      check({tag, "_digits"}, 32'(digits), 32'(e.digits));
    end
    if (release_out) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]    held_res;
    logic [DW-1:0] held_dig;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_eqgtlt", 32'({eq, gt, lt}), 32'd0);
    check("rst_digits", 32'(digits), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start(16'h1234, 16'h1234, 1'b0);  wait_result("eq_full", 1'b1);
    start(16'h9000, 16'h1000, 1'b0);  wait_result("uns_gt", 1'b1);
    start(16'h1000, 16'h9000, 1'b0);  wait_result("uns_lt", 1'b1);
    start(16'h9000, 16'h1000, 1'b1);  wait_result("sgn_first", 1'b1);
    start(16'hFFFF, 16'hFFFE, 1'b1);  wait_result("sgn_ffff", 1'b1);
    start(16'h7FFF, 16'h8000, 1'b1);  wait_result("sgn_edge", 1'b1);
    start(16'h12A4, 16'h12A3, 1'b0);  wait_result("last_digit", 1'b1);
    start(16'h0000, 16'h0000, 1'b0);  wait_result("zeros", 1'b1);

    // Backpressure: result held while out_ready is low, new pair must not be captured
    start(16'h12B0, 16'h12C0, 1'b0);
    wait_result("bp_first", 1'b0);
    held_res  = {eq, gt, lt};
    held_dig  = digits;
    in_valid  = 1'b1;
    a         = 16'h0F00;
    b         = 16'h0E00;
    is_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = a + 16'h0001;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_res", 32'({eq, gt, lt}), 32'(held_res));
      check("bp_hold_dig", 32'(digits), 32'(held_dig));
    end
    a = 16'h0F00;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    sb.push_back(model(16'h0F00, 16'h0E00, 1'b0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp_next", 1'b1);

    // Asynchronous reset while scanning digit 2
    start(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_eqgtlt", 32'({eq, gt, lt}), 32'd0);
    check("mid_rst_digits", 32'(digits), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    check("mid_rst_no_result", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start(16'h0001, 16'h0000, 1'b0);  wait_result("post_rst", 1'b1);

    // A spread of pseudo-random pairs
    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] x, y;
      x = WIDTH'($urandom);
      y = (i % 3 == 0) ? (x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1))) : WIDTH'($urandom);
      start(x, y, 1'(i % 2));
      wait_result("rand", 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
